// File: rtl/expression_pipe.sv
// expression_pipe: pipelined multi-lane expression evaluator.
//
// Evaluates one operation (selected by op) on LANES independent operand
// pairs per accepted transaction. Each lane is signed or unsigned according
// to SIGNED_MASK. The result is computed when the transaction is accepted,
// then carried through STAGES register stages to the output. A per-lane
// accumulator supports the ACC/CLR operations.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   transaction offered
//   in_ready   block can accept (global advance enable)
//   op         operation code, sampled with the transaction
//   a, b       lane operands, lane i = x[i*W +: W]
//   out_valid  result valid
//   out_ready  consumer accepts result
//   y          lane results, same packing as a/b
//   flag       per-lane status bit
//   par        per-lane parity of y (only with EXPRESSION_PIPE_PARITY_EN)
//
// Optional feature: define EXPRESSION_PIPE_PARITY_EN to add the par output.

module expression_pipe #(
    parameter int unsigned      LANES       = 6,
    parameter int unsigned      W           = 6,
    parameter logic [LANES-1:0] SIGNED_MASK = 6'b111000,
    parameter int unsigned      STAGES      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y,
    output logic [LANES-1:0]   flag
`ifdef EXPRESSION_PIPE_PARITY_EN
    ,
    output logic [LANES-1:0]   par
`endif
);

    localparam int unsigned LW = LANES * W;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;
    localparam logic [2:0] OP_ACC = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    logic             adv_c;
    logic             accept_c;
    logic [LW-1:0]    res_c;
    logic [LANES-1:0] flg_c;
    logic [LW-1:0]    acc_q;

    logic [STAGES-1:0] v_q;
    logic [LW-1:0]     y_q [STAGES];
    logic [LANES-1:0]  f_q [STAGES];

`ifdef EXPRESSION_PIPE_PARITY_EN
    logic [LANES-1:0]  par_c;
    logic [LANES-1:0]  p_q [STAGES];
`endif

    // Whole pipe shifts together whenever the output slot is free or draining
    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c;
    assign accept_c = in_valid && adv_c;

    // Per-lane datapath, evaluated on the operands being offered
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam bit SG = SIGNED_MASK[i];

        logic [W-1:0]   al, bl, cl;
        logic [W-1:0]   pl, ql;
        logic [W-1:0]   dl, shr, lowm, eff;
        logic [W-1:0]   rl;
        logic           fl;
        logic [W:0]     sum;
        logic [2*W-1:0] ae, be;

        assign al = a[i*W +: W];
        assign bl = b[i*W +: W];
        assign cl = acc_q[i*W +: W];

        assign ae = SG ? {{W{al[W-1]}}, al} : {{W{1'b0}}, al};
        assign be = SG ? {{W{bl[W-1]}}, bl} : {{W{1'b0}}, bl};

        // ACC reuses the adder with (acc, a) as operands
        assign pl  = (op == OP_ACC) ? cl : al;
        assign ql  = (op == OP_ACC) ? al : bl;
        assign sum = {1'b0, pl} + {1'b0, ql};
        assign dl  = al - bl;

        // Oversized shifts saturate: a signed lane can lose at most W-1 bits
        // before it is all sign copies, an unsigned lane loses everything.
        always_comb begin
            eff = bl;
            if (32'(bl) >= 32'(W)) begin
                eff = SG ? W'(W - 1) : W'(W);
            end
        end

        assign shr  = W'(ae >> eff);
        assign lowm = ~({W{1'b1}} << eff);

        always_comb begin
            rl = '0;
            fl = 1'b0;
            case (op)
                OP_ADD, OP_ACC: begin
                    rl = sum[W-1:0];
                    fl = SG ? ((pl[W-1] == ql[W-1]) && (sum[W-1] != pl[W-1]))
                            : sum[W];
                end
                OP_SUB: begin
                    rl = dl;
                    fl = SG ? ((al[W-1] != bl[W-1]) && (dl[W-1] != al[W-1]))
                            : (al < bl);
                end
                OP_AND: begin
                    rl = al & bl;
                    fl = ((al & bl) == '0);
                end
                OP_XOR: begin
                    rl = al ^ bl;
                    fl = ((al ^ bl) == '0);
                end
                OP_SHR: begin
                    rl = shr;
                    fl = |(al & lowm);
                end
                OP_CMP: begin
                    // Extended operands make one signed compare valid for both lane kinds
                    rl = W'($signed(ae) >= $signed(be));
                    fl = (al == bl);
                end
                default: begin
                    rl = '0;
                    fl = 1'b0;
                end
            endcase
        end

        assign res_c[i*W +: W] = rl;
        assign flg_c[i]        = fl;
`ifdef EXPRESSION_PIPE_PARITY_EN
        assign par_c[i]        = ^rl;
`endif
    end

    // Accumulators change only at accept so chained ACCs see their predecessor
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept_c && (op == OP_ACC)) begin
            acc_q <= res_c;
        end else if (accept_c && (op == OP_CLR)) begin
            acc_q <= '0;
        end
    end

    // Result pipeline; bubbles carry zero payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                y_q[k] <= '0;
                f_q[k] <= '0;
`ifdef EXPRESSION_PIPE_PARITY_EN
                p_q[k] <= '0;
`endif
            end
        end else if (adv_c) begin
            v_q[0] <= in_valid;
            y_q[0] <= in_valid ? res_c : '0;
            f_q[0] <= in_valid ? flg_c : '0;
`ifdef EXPRESSION_PIPE_PARITY_EN
            p_q[0] <= in_valid ? par_c : '0;
`endif
            for (int k = 1; k < int'(STAGES); k++) begin
                v_q[k] <= v_q[k-1];
                y_q[k] <= y_q[k-1];
                f_q[k] <= f_q[k-1];
`ifdef EXPRESSION_PIPE_PARITY_EN
                p_q[k] <= p_q[k-1];
`endif
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign flag      = f_q[STAGES-1];
`ifdef EXPRESSION_PIPE_PARITY_EN
    assign par       = p_q[STAGES-1];
`endif

endmodule

// File: tb/tb_expression_pipe.sv
// Directed bench for expression_pipe with default parameters
// (LANES=6, W=6, SIGNED_MASK=6'b111000, STAGES=2).

module tb_expression_pipe;

    localparam int unsigned LANES = 6;
    localparam int unsigned W     = 6;
    localparam int unsigned LW    = LANES * W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [LW-1:0]    a;
    logic [LW-1:0]    b;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    y;
    logic [LANES-1:0] flag;
`ifdef EXPRESSION_PIPE_PARITY_EN
    logic [LANES-1:0] par;
`endif

    expression_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flag      (flag)
`ifdef EXPRESSION_PIPE_PARITY_EN
        ,
        .par       (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [LW-1:0]    a;
        logic [LW-1:0]    b;
        logic [LW-1:0]    y;
        logic [LANES-1:0] f;
    } vec_t;

    int tests = 0;
    int fails = 0;

    function automatic logic [LW-1:0] pk(input int x0, input int x1, input int x2,
                                         input int x3, input int x4, input int x5);
        pk = {6'(x5), 6'(x4), 6'(x3), 6'(x2), 6'(x1), 6'(x0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One isolated transaction: accept, no output one cycle later, result two cycles later
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
        #1;
        chk({nm, " in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, " early out_valid"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        chk({nm, " out_valid"}, 64'(out_valid), 64'(1));
        chk({nm, " y"}, 64'(y), 64'(v.y));
        chk({nm, " flag"}, 64'(flag), 64'(v.f));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tv [12];
        logic [LW-1:0] bp_val [3];
        logic [LW-1:0] got [$];
        logic [LW-1:0] held;
        logic          have_held;
        int            idx;
        logic          acc;

        // op, a, b, expected y, expected flag
        tv[0]  = '{3'd6, pk(0,20,0,20,0,0),   pk(9,9,9,9,9,9),   pk(0,20,0,20,0,0),  6'b000000};
        tv[1]  = '{3'd6, pk(0,20,0,20,0,0),   pk(9,9,9,9,9,9),   pk(0,40,0,40,0,0),  6'b001000};
        tv[2]  = '{3'd0, pk(63,10,0,31,32,0), pk(1,20,0,1,63,0), pk(0,30,0,32,31,0), 6'b011001};
        tv[3]  = '{3'd1, pk(5,7,0,32,0,3),    pk(6,3,0,1,0,5),   pk(63,4,0,31,0,62), 6'b001001};
        tv[4]  = '{3'd6, pk(0,20,0,20,0,0),   pk(0,0,0,0,0,0),   pk(0,60,0,60,0,0),  6'b000000};
        tv[5]  = '{3'd2, pk(12,63,0,0,0,0),   pk(3,5,0,0,0,0),   pk(0,5,0,0,0,0),    6'b111101};
        tv[6]  = '{3'd3, pk(9,5,0,0,0,0),     pk(9,3,0,0,0,0),   pk(0,6,0,0,0,0),    6'b111101};
        tv[7]  = '{3'd4, pk(32,40,7,45,3,32), pk(8,3,6,2,1,8),   pk(0,5,0,59,1,63),  6'b011101};
        tv[8]  = '{3'd5, pk(9,0,63,0,63,5),   pk(9,0,1,0,1,62),  pk(1,1,1,1,0,1),    6'b001011};
        tv[9]  = '{3'd6, pk(0,20,0,20,0,0),   pk(1,1,1,1,1,1),   pk(0,16,0,16,0,0),  6'b000010};
        tv[10] = '{3'd7, pk(7,7,7,7,7,7),     pk(7,7,7,7,7,7),   pk(0,0,0,0,0,0),    6'b000000};
        tv[11] = '{3'd6, pk(0,5,0,0,0,0),     pk(0,0,0,0,0,0),   pk(0,5,0,0,0,0),    6'b000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset y", 64'(y), 64'(0));
        chk("reset flag", 64'(flag), 64'(0));
        chk("reset in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 12; i++) begin
            run_vec(tv[i], $sformatf("vec%0d", i));
        end

        // Backpressure: consumer stalls for 4 cycles while 3 transactions are offered
        bp_val[0] = pk(11,11,11,11,11,11);
        bp_val[1] = pk(22,22,22,22,22,22);
        bp_val[2] = pk(33,33,33,33,33,33);
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        have_held = 1'b0;
        held = '0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 4) out_ready = 1'b1;
            in_valid = (idx < 3);
            op = 3'd0;
            a = (idx < 3) ? bp_val[idx] : '0;
            b = '0;
            #1;
            if (out_valid && out_ready) got.push_back(y);
            if (out_valid && !out_ready) begin
                if (have_held) chk("stall y stable", 64'(y), 64'(held));
                held = y;
                have_held = 1'b1;
            end
            if (c == 3) begin
                chk("stall in_ready", 64'(in_ready), 64'(0));
                chk("stall accepts", 64'(idx), 64'(2));
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp result count", 64'(got.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk($sformatf("bp result %0d", i), 64'(got[i]), 64'(bp_val[i]));
            else chk($sformatf("bp result %0d missing", i), 64'(0), 64'(1));
        end

        // Reset with one result at the output and another in flight
        @(negedge clk);
        out_ready = 1'b1;
        op = 3'd6; a = pk(3,3,3,3,3,3); b = '0; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre-reset out_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset out_valid", 64'(out_valid), 64'(0));
        chk("post-reset y", 64'(y), 64'(0));
        chk("post-reset flag", 64'(flag), 64'(0));
        @(negedge clk);
        chk("post-reset no emit", 64'(out_valid), 64'(0));
        run_vec('{3'd6, pk(1,1,1,1,1,1), pk(0,0,0,0,0,0), pk(1,1,1,1,1,1), 6'b000000},
                "acc after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/expression_pipe.md
Name: expression_pipe

Overview:
- Parametrised, pipelined successor to the combinational per-lane expression blocks in the regression set.
- Evaluates one selectable operation on LANES independent operand pairs (a lane, b lane) per transaction.
- Each lane is signed or unsigned by parameter.
- Adds a valid/ready handshake, configurable pipeline depth, per-lane overflow/status flags and per-lane running accumulators.
- Used as a sequential stress target for the mixed-signedness width-rule checks.

Parameters:
- LANES, 6, number of independent operand lanes (1..16)
- W, 6, lane width in bits (2..16)
- SIGNED_MASK, 6'b111000, LANES bits; bit i set = lane i signed, clear = unsigned
- STAGES, 2, pipeline register stages from accept to output (1..4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  transaction offered
- in_ready  out  1  block can accept
- op  in  3  operation code, sampled with the transaction
- a  in  LANES*W  lane operands A; lane i = a[i*W +: W]
- b  in  LANES*W  lane operands B, same packing
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  LANES*W  lane results, same packing
- flag  out  LANES  per-lane status bit

Behaviour:
- Reset:
  - Synchronous, active-low, sampled on clk.
  - On reset: all stage valids 0, out_valid=0, y=0, flag=0, all accumulators 0.
  - Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Handshake:
  - Single global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - Accept occurs when in_valid && in_ready. The whole pipe shifts on adv.
  - Bubbles are not collapsed.
  - Latency from accept to out_valid is exactly STAGES cycles when unstalled.
  - y and flag hold stable while out_valid && !out_ready.
  - Results emerge in accept order, with no loss or duplication.
- Operand extension: lane operands are sign- or zero-extended per SIGNED_MASK to 2W internally. Results are truncated to W bits.
- op encoding (computation is done at accept stage; result rides the pipe):
  - 0 ADD: y=a+b. flag = signed overflow (signed lane) or carry out (unsigned lane).
  - 1 SUB: y=a-b. flag = signed overflow or borrow.
  - 2 AND: y=a&b. flag = (y==0).
  - 3 XOR: y=a^b. flag = (y==0).
  - 4 SHR: shift amount = b interpreted unsigned.
    - Arithmetic shift on signed lanes, logical on unsigned lanes.
    - Amount >= W gives 0 (unsigned lane) or W copies of a's MSB (signed lane).
    - flag = any 1 bit shifted out.
  - 5 CMP: y = zero-extended (a >= b), compared with lane signedness. flag = (a == b).
  - 6 ACC:
    - acc_i <= acc_i + a_i, wrapping modulo 2^W; y = new acc_i.
    - flag = overflow as ADD. b is ignored.
  - 7 CLR: acc_i <= 0, y = 0, flag = 0.
- Accumulators:
  - Updated only at accept, so back-to-back ACC transactions chain correctly regardless of stalls.
  - A non-ACC/CLR op leaves accumulators unchanged.
- Simultaneous accept and emit in the same cycle is legal and sustains 1 transaction per cycle.

Optional Feature:
- Macro: EXPRESSION_PIPE_PARITY_EN.
- Defined: adds output port par [LANES-1:0], with par[i] = ^y lane i. It is registered with y and resets to 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- ADD, defaults: lane0 a=63 b=1 -> y0=0, flag0=1; lane3 a=31 b=1 -> y3=6'b100000, flag3=1; out_valid exactly 2 cycles after accept.
- SHR: lane5 a=6'b100000 b=8 -> y5=6'b111111, flag5=0; lane0 a=6'b100000 b=8 -> y0=0, flag0=1; lane4 a=6'b000011 b=1 -> y4=1, flag4=1.
- ACC: four accepted ACC ops with lane1 a=20 -> y1 = 20, 40, 60, 16; flag1 = 0, 0, 0, 1. A following CLR then ACC a=5 -> y1=5.
- Backpressure: out_ready=0 for 4 cycles while offering 3 transactions -> in_ready drops after 2 accepts. On release, 3 results in order, none lost or duplicated, y stable during the stall.
- CMP: lane4 signed a=-1 b=1 -> y4=0, flag4=0; lane2 unsigned a=63 b=1 -> y2=1, flag2=0; lane0 a=b=9 -> y0=1, flag0=1.
- Reset: rst_n=0 for one cycle while out_valid=1 and accumulators nonzero -> out_valid=0 next cycle, y=0, then ACC a=1 -> y=1 on every lane.
